// File: rtl/expon_iter.sv
// expon_iter - iterative fixed-point exponential, y = exp(x) for x <= 0.
//
// The argument is first range-reduced by whole multiples of ln2, which become
// a final right shift of the result. The remainder, in (-ln2, 0], is then
// removed by multiplicative normalisation: for k = 1..ITER, if adding
// -ln(1-2^-k) keeps the remainder non-positive, the accumulator is multiplied
// by (1 - 2^-k) with a shift and subtract.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   x_in      signed argument, Q(W-FRAC).FRAC, captured on the accepted start
//   busy      high from the accepted start until done
//   done      one-cycle pulse when y is valid
//   y         unsigned result, Q(W-FRAC).FRAC, held until the next result
//   range_err x_in was positive; the result is then forced to 1.0
module expon_iter #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int ITER  = 12,
  parameter int GUARD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  output logic                busy,
  output logic                done,
  output logic        [W-1:0] y,
  output logic                range_err
);

  // Accumulator holds 1.0 with GUARD extra fractional bits below the output LSB.
  localparam int YW    = FRAC + GUARD + 1;
  // ROM entries are stored in Q0.16 and rounded half-up down to FRAC bits.
  localparam int SH    = 16 - FRAC;
  localparam int HALF  = (1 << SH) >> 1;
  // ln2 is the k=1 table entry, so it shares the same rounding.
  localparam int LN2_I = (45426 + HALF) >> SH;

  localparam logic signed [W-1:0] LN2     = W'(LN2_I);
  localparam logic signed [W-1:0] NEG_LN2 = W'(-LN2_I);
  localparam logic        [YW-1:0] ONE_ACC = {1'b1, {(FRAC + GUARD){1'b0}}};
  localparam logic        [4:0]    N_MAX   = 5'(FRAC + 1);
  localparam logic        [4:0]    K_LAST  = 5'(ITER);

  // -ln(1 - 2^-k) scaled to FRAC fractional bits.
  function automatic logic signed [W:0] lnTerm(input logic [4:0] k);
    int raw;
    case (k)
      5'd1:    raw = 45426;
      5'd2:    raw = 18854;
      5'd3:    raw = 8751;
      5'd4:    raw = 4230;
      5'd5:    raw = 2081;
      5'd6:    raw = 1032;
      5'd7:    raw = 514;
      5'd8:    raw = 257;
      5'd9:    raw = 128;
      5'd10:   raw = 64;
      5'd11:   raw = 32;
      5'd12:   raw = 16;
      5'd13:   raw = 8;
      5'd14:   raw = 4;
      5'd15:   raw = 2;
      5'd16:   raw = 1;
      default: raw = 0;
    endcase
    return (W + 1)'((raw + HALF) >> SH);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_NORM,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic signed [W-1:0]   x_q;
  logic        [YW-1:0]  yAcc_q;
  logic        [4:0]     n_q;
  logic        [4:0]     k_q;
  logic                  busy_q;
  logic                  done_q;
  logic        [W-1:0]   y_q;
  logic                  rangeErr_q;

  logic signed [W:0]     diff_d;
  logic                  normTake_d;
  logic        [YW-1:0]  yAccShr_d;
  logic                  xPositive_d;

  // One extra bit on the trial sum so x + L[k] can never wrap. A factor is
  // taken only when the remainder would stay at or below zero.
  always_comb begin
    diff_d      = {x_q[W-1], x_q} + lnTerm(k_q);
    normTake_d  = diff_d[W] || (diff_d == '0);
    yAccShr_d   = yAcc_q >> k_q;
    xPositive_d = !x_in[W-1] && (x_in != '0);
  end

  // Controller and datapath in a single register block. Every output is a
  // register, so done and busy are glitch-free for the requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      yAcc_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      y_q        <= '0;
      rangeErr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // A positive argument is flagged and evaluated as exp(0).
            x_q        <= xPositive_d ? '0 : x_in;
            rangeErr_q <= xPositive_d;
            yAcc_q     <= ONE_ACC;
            n_q        <= '0;
            k_q        <= 5'd1;
            busy_q     <= 1'b1;
            state_q    <= S_RED;
          end
        end
        S_RED: begin
          if ((x_q <= NEG_LN2) && (n_q < N_MAX)) begin
            x_q <= x_q + LN2;
            n_q <= n_q + 5'd1;
          end else if (n_q == N_MAX) begin
            // The final shift would clear every bit, so skip straight to zero.
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (normTake_d) begin
            x_q    <= diff_d[W-1:0];
            yAcc_q <= yAcc_q - yAccShr_d;
          end
          if (k_q == K_LAST) begin
            state_q <= S_SHIFT;
          end else begin
            k_q <= k_q + 5'd1;
          end
        end
        S_SHIFT: begin
          // Drop the guard bits, then apply 2^-n from the range reduction.
          y_q     <= W'((yAcc_q >> GUARD) >> n_q);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign y         = y_q;
  assign range_err = rangeErr_q;

endmodule

// File: tb/tb_expon_iter.sv
// tb_expon_iter - scoreboard bench for expon_iter.
// A default-parameter instance gets directed and random arguments; a W=20
// instance covers the underflow early exit. Each accepted request pushes the
// expected result and latency, and a monitor per instance pops on done.
module tb_expon_iter;

  localparam int    W     = 16;
  localparam int    WW    = 20;
  localparam int    FRAC  = 12;
  localparam int    ITER  = 12;
  localparam real   ONE   = 4096.0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic signed [W-1:0]  xIn;
  logic                 busy;
  logic                 done;
  logic        [W-1:0]  y;
  logic                 rangeErr;

  logic                 startW;
  logic signed [WW-1:0] xInW;
  logic                 busyW;
  logic                 doneW;
  logic        [WW-1:0] yW;
  logic                 rangeErrW;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    real expY;
    real tol;
    int  expErr;
    int  expLat;
    int  startCyc;
  } exp_t;

  exp_t sbq[$];
  exp_t sbqW[$];
  exp_t monE;
  exp_t monEW;

  expon_iter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (xIn),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .range_err (rangeErr)
  );

  expon_iter #(.W(WW)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (startW),
    .x_in      (xInW),
    .busy      (busyW),
    .done      (doneW),
    .y         (yW),
    .range_err (rangeErrW)
  );

  always #5 clk = ~clk;

  // Edge counter; cycle c of an operation is c edges after the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: true exponential, reductions counted as whole multiples of ln2.
  function automatic exp_t model(input int x, input int startCyc);
    exp_t e;
    int   ln2;
    int   nRed;
    ln2 = int'($floor(0.6931471805599453 * ONE + 0.5));
    e.startCyc = startCyc;
    e.expErr   = 0;
    if (x >= 0) begin
      e.expY   = ONE;
      e.tol    = 0.0;
      e.expErr = (x > 0) ? 1 : 0;
      e.expLat = ITER + 3;
    end else begin
      nRed = (-x) / ln2;
      if (nRed >= FRAC + 1) begin
        e.expY   = 0.0;
        e.tol    = 0.0;
        e.expLat = FRAC + 3;
      end else begin
        e.expY   = $exp(real'(x) / ONE) * ONE;
        e.tol    = 4.0;
        e.expLat = nRed + ITER + 3;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic checkOutputNear(input string name, input int act, input real expv, input real tol);
    real d;
    compared++;
    d = real'(act) - expv;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %.2f +/- %.1f", name, act, expv, tol);
    end
  endtask

  // Main instance monitor.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending request (y=%0d)", y);
      end else begin
        monE = sbq.pop_front();
        checkOutputNear("y", int'(y), monE.expY, monE.tol);
        checkOutput("range_err", int'(rangeErr), monE.expErr);
        checkOutput("latency", cyc - monE.startCyc, monE.expLat);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("y_le_one", (int'(y) <= 4096) ? 1 : 0, 1);
      end
    end
  end

  // Wide instance monitor.
  always @(negedge clk) begin
    if (doneW) begin
      if (sbqW.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done_wide: got done=1 expected no pending request (y=%0d)", yW);
      end else begin
        monEW = sbqW.pop_front();
        checkOutputNear("wide_y", int'(yW), monEW.expY, monEW.tol);
        checkOutput("wide_range_err", int'(rangeErrW), monEW.expErr);
        checkOutput("wide_latency", cyc - monEW.startCyc, monEW.expLat);
        checkOutput("wide_busy_at_done", int'(busyW), 0);
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout: got busy=%0d done=%0d expected idle within 200 cycles", busy, done);
    end
  endtask

  task automatic waitIdleWide();
    int n;
    n = 0;
    while ((busyW || doneW) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout_wide: got busy=%0d done=%0d expected idle within 200 cycles", busyW, doneW);
    end
  endtask

  task automatic applyStimulus(input int x);
    waitIdle();
    @(negedge clk);
    start = 1'b1;
    xIn   = W'(x);
    sbq.push_back(model(x, cyc));
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
  endtask

  task automatic applyStimulusWide(input int x);
    waitIdleWide();
    @(negedge clk);
    startW = 1'b1;
    xInW   = WW'(x);
    sbqW.push_back(model(x, cyc));
    @(negedge clk);
    startW = 1'b0;
    checkOutput("wide_busy_after_start", int'(busyW), 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1000000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int x;
    int t;
    rst_n  = 1'b0;
    start  = 1'b0;
    xIn    = '0;
    startW = 1'b0;
    xInW   = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_y", int'(y), 0);
    checkOutput("reset_range_err", int'(rangeErr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arguments including exact multiples of ln2 and the most negative input.
    applyStimulus(0);
    applyStimulus(-2048);
    applyStimulus(-4096);
    applyStimulus(-32768);
    applyStimulus(1024);
    applyStimulus(-1);
    applyStimulus(-2839);
    applyStimulus(32767);

    // Underflow boundary on the wide instance: 13 multiples of ln2 is the limit.
    applyStimulusWide(-49152);
    applyStimulusWide(-36907);
    applyStimulusWide(-36906);
    applyStimulusWide(-32768);
    applyStimulusWide(-524288);
    applyStimulusWide(2000);
    waitIdleWide();

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      x = int'($urandom_range(1, 32767));
      else if (r == 1) x = -int'($urandom_range(0, 64));
      else             x = -int'($urandom_range(0, 32768));
      applyStimulus(x);
    end

    // A start while busy must be dropped, not queued.
    applyStimulus(1024);
    repeat (3) @(negedge clk);
    start = 1'b1;
    xIn   = W'(-4096);
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an operation clears outputs without a clock edge.
    applyStimulus(500);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_y", int'(y), 0);
    checkOutput("midreset_range_err", int'(rangeErr), 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    applyStimulus(-4096);

    t = 0;
    while ((sbq.size() > 0 || sbqW.size() > 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbq.size() + sbqW.size());
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
